// File: rtl/seg7_scan_controller.sv
// rtl/seg7_scan_controller.sv - 8-digit seven-segment scan scheduler with double-buffered word load
// Optional leading-zero blanking when SEG7_LZB_EN is defined.
module seg7_scan_controller #(
   parameter int SCAN_DIV  = 100000,
   parameter int BLANK_CYC = 16
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        load_valid,
   output logic        load_ready,
   input  logic [31:0] load_data,
   input  logic [7:0]  dp_in,
   output logic [6:0]  out7,
   output logic        dp_out,
   output logic [7:0]  en_out,
   output logic        frame_done
);

   localparam int MAXC = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
   localparam int CW   = $clog2(MAXC + 1);
   localparam logic [CW-1:0] SHOW_LAST  = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] BLANK_LAST = (BLANK_CYC > 0) ? CW'(BLANK_CYC - 1) : '0;

   typedef enum logic {SHOW, BLANK} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [2:0]    idx, idx_nxt;
   logic          wrap;

   logic [31:0]   active, pend_data;
   logic [7:0]    dp_act, pend_dp;
   logic          pend_full, pend_full_nxt, xfer;
   logic [3:0]    nib;
   logic [7:0]    lz;

   function automatic logic [6:0] enc(input logic [3:0] n);
      case (n)
         4'h0: enc = 7'h40;  4'h1: enc = 7'h79;  4'h2: enc = 7'h24;  4'h3: enc = 7'h30;
         4'h4: enc = 7'h19;  4'h5: enc = 7'h12;  4'h6: enc = 7'h02;  4'h7: enc = 7'h78;
         4'h8: enc = 7'h00;  4'h9: enc = 7'h10;  4'hA: enc = 7'h08;  4'hB: enc = 7'h03;
         4'hC: enc = 7'h46;  4'hD: enc = 7'h21;  4'hE: enc = 7'h06;  default: enc = 7'h0E;
      endcase
   endfunction

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state <= SHOW;
         cnt   <= '0;
         idx   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         idx   <= idx_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt + CW'(1);
      idx_nxt   = idx;
      wrap      = 1'b0;
      case (state)
         SHOW: begin
            if (cnt == SHOW_LAST) begin
               cnt_nxt = '0;
               if (BLANK_CYC == 0) begin
                  idx_nxt = idx + 3'd1;
                  wrap    = (idx == 3'd7);
               end else begin
                  state_nxt = BLANK;
               end
            end
         end
         BLANK: begin
            if (cnt == BLANK_LAST) begin
               cnt_nxt   = '0;
               idx_nxt   = idx + 3'd1;
               wrap      = (idx == 3'd7);
               state_nxt = SHOW;
            end
         end
         default: begin
            state_nxt = SHOW;
            cnt_nxt   = '0;
         end
      endcase
   end

   // Ready is low whenever pending is full, so a transfer never meets a swap on one edge.
   assign xfer          = load_valid & load_ready;
   assign pend_full_nxt = xfer ? 1'b1 : (wrap ? 1'b0 : pend_full);
   assign nib           = active[{idx, 2'b00} +: 4];

`ifdef SEG7_LZB_EN
   logic hz;
   always_comb begin
      lz = 8'h00;
      hz = 1'b1;
      for (int i = 7; i >= 1; i--) begin
         hz    = hz & (active[4*i +: 4] == 4'h0);
         lz[i] = hz;
      end
   end
`else
   assign lz = 8'h00;
`endif

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         active     <= '0;
         dp_act     <= '0;
         pend_data  <= '0;
         pend_dp    <= '0;
         pend_full  <= 1'b0;
         load_ready <= 1'b1;
         en_out     <= 8'hFF;
         out7       <= 7'h7F;
         dp_out     <= 1'b1;
         frame_done <= 1'b0;
      end else begin
         if (wrap && pend_full) begin
            active <= pend_data;
            dp_act <= pend_dp;
         end
         if (xfer) begin
            pend_data <= load_data;
            pend_dp   <= dp_in;
         end
         pend_full  <= pend_full_nxt;
         load_ready <= ~pend_full_nxt;
         frame_done <= wrap;
         if (state == SHOW) begin
            en_out <= ~(8'h01 << idx);
            out7   <= lz[idx] ? 7'h7F : enc(nib);
            dp_out <= ~dp_act[idx];
         end else begin
            en_out <= 8'hFF;
            out7   <= 7'h7F;
            dp_out <= 1'b1;
         end
      end
   end

endmodule
